osc_sweep_ctrl: RTL

Measurement sequencer for the ring-oscillator clock-source selector. On command it steps `clksel` through a masked set of oscillator selections, lets each settle, counts rising edges of a divided oscillator tap over a fixed window of `clk` cycles, and reports a count per selection plus the fastest selection found. It sits between the top-level user inputs and the oscillator mux/divider, replacing direct pin control of `clksel` when a sweep is running.

---
 rtl/osc_sweep_pkg.sv | 15 +
 rtl/osc_edge_sync.sv | 28 ++
 rtl/osc_sweep_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/osc_sweep_pkg.sv
// Shared types and widths for the oscillator sweep sequencer.
package osc_sweep_pkg;

  localparam int SEL_W  = 4;
  localparam int MASK_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_REPORT  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchroniser for the divided oscillator tap, followed by a
// previous-value register that turns each rising edge into a one-cycle pulse.
module osc_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/osc_sweep_ctrl.sv
// Sweeps clksel over the masked selections, counts oscillator edges in a
// fixed window per selection and reports each count plus the fastest one.
module osc_sweep_ctrl
  import osc_sweep_pkg::*;
#(
  parameter int WINDOW_BITS   = 10,
  parameter int COUNT_BITS    = 12,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [MASK_W-1:0]     sel_mask,
  input  logic                  osc_in,
  output logic [SEL_W-1:0]      clksel,
  output logic                  busy,
  output logic                  result_valid,
  output logic [SEL_W-1:0]      result_sel,
  output logic [COUNT_BITS-1:0] result_count,
  output logic                  done,
  output logic [SEL_W-1:0]      best_sel,
  output logic [COUNT_BITS-1:0] best_count,
  output logic                  best_valid,
  output state_t                state_dbg
);

  localparam int TMR_W = ((WINDOW_BITS > $clog2(SETTLE_CYCLES)) ?
                          WINDOW_BITS : $clog2(SETTLE_CYCLES)) + 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'((1 << WINDOW_BITS) - 1);

  state_t state_q, state_d;

  logic [SEL_W-1:0]      clksel_q, clksel_d;
  logic [SEL_W-1:0]      result_sel_q, result_sel_d;
  logic [SEL_W-1:0]      best_sel_q, best_sel_d;
  logic [SEL_W-1:0]      run_sel_q, run_sel_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  logic [COUNT_BITS-1:0] result_count_q, result_count_d;
  logic [COUNT_BITS-1:0] best_count_q, best_count_d;
  logic [COUNT_BITS-1:0] run_cnt_q, run_cnt_d;
  logic                  run_valid_q, run_valid_d;
  logic                  best_valid_q, best_valid_d;
  logic                  busy_q, busy_d;
  logic                  result_valid_q, result_valid_d;
  logic                  done_q, done_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;

  logic             rise;
  logic             start_ok;
  logic             first_found, nxt_found;
  logic [SEL_W-1:0] first_sel, nxt_sel;

  osc_edge_sync u_sync (
    .clk_i   (clk),
    .rst_i   (reset),
    .async_i (osc_in),
    .rise_o  (rise)
  );

  assign start_ok = start & ~abort;

  // Descending scan: the last hit is the lowest set bit (overall / above clksel).
  always_comb begin
    first_found = 1'b0;
    first_sel   = '0;
    nxt_found   = 1'b0;
    nxt_sel     = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (sel_mask[i]) begin
        first_found = 1'b1;
        first_sel   = SEL_W'(i);
        if (i > int'(clksel_q)) begin
          nxt_found = 1'b1;
          nxt_sel   = SEL_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      clksel_q       <= '0;
      result_sel_q   <= '0;
      best_sel_q     <= '0;
      run_sel_q      <= '0;
      cnt_q          <= '0;
      result_count_q <= '0;
      best_count_q   <= '0;
      run_cnt_q      <= '0;
      run_valid_q    <= 1'b0;
      best_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
      tmr_q          <= '0;
    end else begin
      state_q        <= state_d;
      clksel_q       <= clksel_d;
      result_sel_q   <= result_sel_d;
      best_sel_q     <= best_sel_d;
      run_sel_q      <= run_sel_d;
      cnt_q          <= cnt_d;
      result_count_q <= result_count_d;
      best_count_q   <= best_count_d;
      run_cnt_q      <= run_cnt_d;
      run_valid_q    <= run_valid_d;
      best_valid_q   <= best_valid_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
      tmr_q          <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start) state_d = first_found ? ST_SELECT : ST_DONE;
        ST_SELECT:  if (tmr_q == SETTLE_LAST) state_d = ST_MEASURE;
        ST_MEASURE: if (tmr_q == WIN_LAST) state_d = ST_REPORT;
        ST_REPORT:  state_d = nxt_found ? ST_SELECT : ST_DONE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so result_valid and done are
  // high exactly during the REPORT and DONE cycles; each is a one-cycle pulse
  // qualifying its data, with no back-pressure from the consumer.
  always_comb begin
    clksel_d       = clksel_q;
    result_sel_d   = result_sel_q;
    result_count_d = result_count_q;
    best_sel_d     = best_sel_q;
    best_count_d   = best_count_q;
    best_valid_d   = best_valid_q;
    run_sel_d      = run_sel_q;
    run_cnt_d      = run_cnt_q;
    run_valid_d    = run_valid_q;
    cnt_d          = cnt_q;
    tmr_d          = '0;

    if (state_d == state_q &&
        (state_q == ST_SELECT || state_q == ST_MEASURE)) begin
      tmr_d = tmr_q + TMR_W'(1);
    end

    if (state_q == ST_SELECT) begin
      cnt_d = '0;
    end else if (state_q == ST_MEASURE && rise && !(&cnt_q)) begin
      cnt_d = cnt_q + COUNT_BITS'(1);
    end

    if (state_q == ST_IDLE && start_ok) begin
      run_sel_d   = '0;
      run_cnt_d   = '0;
      run_valid_d = 1'b0;
    end else if (state_q == ST_REPORT && (!run_valid_q || cnt_q > run_cnt_q)) begin
      run_sel_d   = clksel_q;
      run_cnt_d   = cnt_q;
      run_valid_d = 1'b1;
    end

    if (state_d == ST_SELECT && state_q == ST_IDLE) clksel_d = first_sel;
    if (state_d == ST_SELECT && state_q == ST_REPORT) clksel_d = nxt_sel;

    if (state_d == ST_REPORT) begin
      result_sel_d   = clksel_q;
      result_count_d = cnt_d;
    end

    if (state_d == ST_DONE) begin
      best_sel_d   = run_sel_d;
      best_count_d = run_cnt_d;
      best_valid_d = run_valid_d;
    end

    busy_d         = (state_d != ST_IDLE);
    result_valid_d = (state_d == ST_REPORT);
    done_d         = (state_d == ST_DONE);
  end

  assign clksel       = clksel_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_sel   = result_sel_q;
  assign result_count = result_count_q;
  assign done         = done_q;
  assign best_sel     = best_sel_q;
  assign best_count   = best_count_q;
  assign best_valid   = best_valid_q;
  assign state_dbg    = state_q;

endmodule
